// File: rtl/axis_hbm_burst_writer_if.sv
// rtl/axis_hbm_burst_writer_if.sv - stream input and AXI4 write channels of the HBM burst writer
interface axis_hbm_burst_writer_if #(
  parameter int phit_size          = 512,
  parameter int C_M_AXI_ADDR_WIDTH = 64
);
  logic [phit_size-1:0]          axis_tdata;
  logic                          axis_tvalid;
  logic                          axis_tlast;
  logic                          axis_tready;

  logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_awaddr;
  logic [7:0]                    m_axi_awlen;
  logic                          m_axi_awvalid;
  logic                          m_axi_awready;
  logic [phit_size-1:0]          m_axi_wdata;
  logic [phit_size/8-1:0]        m_axi_wstrb;
  logic                          m_axi_wlast;
  logic                          m_axi_wvalid;
  logic                          m_axi_wready;
  logic [1:0]                    m_axi_bresp;
  logic                          m_axi_bvalid;
  logic                          m_axi_bready;

  modport master (
    input  axis_tdata, axis_tvalid, axis_tlast,
    output axis_tready,
    output m_axi_awaddr, m_axi_awlen, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid,
    output m_axi_bready
  );

  modport slave (
    output axis_tdata, axis_tvalid, axis_tlast,
    input  axis_tready,
    input  m_axi_awaddr, m_axi_awlen, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready
  );
endinterface

// File: rtl/axis_hbm_burst_writer.sv
// rtl/axis_hbm_burst_writer.sv - drains the CGRA output stream into HBM as page-safe AXI4 INCR bursts
// One burst outstanding; a skid FIFO decouples the stream from W-channel backpressure.
module axis_hbm_burst_writer #(
  parameter int phit_size          = 512,
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int MAX_BURST          = 16,
  parameter int FIFO_DEPTH         = 32
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst_n,
  input  logic                          start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] base_addr,
  input  logic [31:0]                   num_beats,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  axis_hbm_burst_writer_if.master       bus
);
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [AW-1:0] addr;
  logic [31:0]   remaining;
  logic [31:0]   total;
  logic [31:0]   accepted;
  logic [31:0]   page_room;
  logic [31:0]   burst_l;
  logic [6:0]    burst_len;
  logic [6:0]    beat_cnt;
  logic          err_q;

  logic [phit_size-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic                 fifo_empty, fifo_full, push, pop;

  logic awvalid, wvalid, bready, tready, wlast_int, aw_hs, w_hs, b_hs;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));

  // Beats left before the 4 KB page boundary, counted from the next burst address.
  assign page_room = 32'd64 - {26'd0, addr[11:6]};

  always_comb begin
    burst_l = remaining;
    if (burst_l > 32'(MAX_BURST)) burst_l = 32'(MAX_BURST);
    if (burst_l > page_room)      burst_l = page_room;
  end

  assign wlast_int = (beat_cnt == burst_len - 7'd1);
  assign aw_hs     = awvalid && bus.m_axi_awready;
  assign w_hs      = wvalid && bus.m_axi_wready;
  assign b_hs      = bready && bus.m_axi_bvalid;
  assign tready    = busy && !fifo_full && (accepted < total);
  assign push      = bus.axis_tvalid && tready;
  assign pop       = w_hs;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = (num_beats == 32'd0) ? S_DONE : S_ADDR;
      end
      S_ADDR: begin
        busy    = 1'b1;
        awvalid = 1'b1;
        if (bus.m_axi_awready) state_nxt = S_DATA;
      end
      S_DATA: begin
        busy   = 1'b1;
        wvalid = !fifo_empty;
        if (wvalid && bus.m_axi_wready && wlast_int) state_nxt = S_RESP;
      end
      S_RESP: begin
        busy   = 1'b1;
        bready = 1'b1;
        if (bus.m_axi_bvalid) state_nxt = (remaining == 32'd0) ? S_DONE : S_ADDR;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bus outputs are forced to zero outside their valid windows so reset drives every output low.
  assign bus.axis_tready   = tready;
  assign bus.m_axi_awvalid = awvalid;
  assign bus.m_axi_awaddr  = awvalid ? addr : '0;
  assign bus.m_axi_awlen   = awvalid ? 8'(burst_l - 32'd1) : 8'd0;
  assign bus.m_axi_wvalid  = wvalid;
  assign bus.m_axi_wdata   = wvalid ? mem[rd_ptr] : '0;
  assign bus.m_axi_wstrb   = wvalid ? '1 : '0;
  assign bus.m_axi_wlast   = wvalid && wlast_int;
  assign bus.m_axi_bready  = bready;
  assign err               = err_q;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      addr      <= '0;
      remaining <= '0;
      total     <= '0;
      accepted  <= '0;
      burst_len <= '0;
      beat_cnt  <= '0;
      err_q     <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        addr      <= base_addr & ~AW'(63);
        remaining <= num_beats;
        total     <= num_beats;
        accepted  <= '0;
        err_q     <= 1'b0;
      end
      if (aw_hs) begin
        addr      <= addr + (AW'(burst_l) << 6);
        remaining <= remaining - burst_l;
        burst_len <= burst_l[6:0];
        beat_cnt  <= '0;
      end
      if (w_hs) beat_cnt <= beat_cnt + 7'd1;
      if (push) begin
        accepted <= accepted + 32'd1;
        if (bus.axis_tlast != (accepted == total - 32'd1)) err_q <= 1'b1;
      end
      if (b_hs && bus.m_axi_bresp != 2'b00) err_q <= 1'b1;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge ap_clk) begin
    if (push) mem[wr_ptr] <= bus.axis_tdata;
  end
endmodule

// File: tb/tb_axis_hbm_burst_writer.sv
// tb/tb_axis_hbm_burst_writer.sv - vector table, randomized transfers and reset corner cases for the burst writer
module tb_axis_hbm_burst_writer;
  localparam int PS = 512;

  logic        ap_clk    = 1'b0;
  logic        ap_rst_n  = 1'b0;
  logic        start     = 1'b0;
  logic [63:0] base_addr = '0;
  logic [31:0] num_beats = '0;
  logic        busy, done, err;

  axis_hbm_burst_writer_if #(.phit_size(PS), .C_M_AXI_ADDR_WIDTH(64)) bus ();

  axis_hbm_burst_writer #(
    .phit_size(PS), .C_M_AXI_ADDR_WIDTH(64), .MAX_BURST(16), .FIFO_DEPTH(32)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start), .base_addr(base_addr),
    .num_beats(num_beats), .busy(busy), .done(done), .err(err), .bus(bus)
  );

  always #5 ap_clk = ~ap_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic bit rnd(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  function automatic logic [511:0] rand_phit();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  typedef struct {
    logic [63:0] base;
    int          n;
    int          aw_rate;
    int          w_rate;
    int          tv_rate;
    int          b_err_burst;
    int          tlast_mode;   // 0 correct, 1 early tlast on beat 0, 2 never
    int          poke;         // extra start pulses while busy and in DONE
    int          exp_bursts;   // -1: take count from the reference model
    bit          exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [63:0] b, input int n, input int aw, input int w, input int tv,
                              input int be, input int tm, input int pk, input int eb, input bit ee);
    vec_t v;
    v.base = b; v.n = n; v.aw_rate = aw; v.w_rate = w; v.tv_rate = tv;
    v.b_err_burst = be; v.tlast_mode = tm; v.poke = pk; v.exp_bursts = eb; v.exp_err = ee;
    return v;
  endfunction

  task automatic idle_inputs();
    start = 1'b0;
    bus.axis_tvalid = 1'b0; bus.axis_tlast = 1'b0; bus.axis_tdata = '0;
    bus.m_axi_awready = 1'b0; bus.m_axi_wready = 1'b0;
    bus.m_axi_bvalid = 1'b0; bus.m_axi_bresp = 2'b00;
  endtask

  task automatic run_xfer(input vec_t v);
    logic [63:0]  ea[$];
    int           el[$];
    bit           elast[$];
    logic [511:0] src[$];
    bit           stl[$];
    logic [63:0]  got_a[$];
    int           got_l[$];
    logic [511:0] got_d[$];
    bit           got_last[$];
    logic [63:0]  a;
    int rem, room, len, si, pend_b, b_issued, done_cyc, first_aw, cyc, extra_done, extra_busy;
    bit b_hs, t_hs, fin, err_at_done;

    // Reference: split the transfer by the burst-length rule, then flag the last beat of each burst.
    a = v.base & ~64'h3F;
    rem = v.n;
    while (rem > 0) begin
      room = 64 - int'(a[11:6]);
      len = rem;
      if (len > 16) len = 16;
      if (len > room) len = room;
      ea.push_back(a);
      el.push_back(len);
      for (int k = 0; k < len; k++) elast.push_back(k == len - 1);
      a = a + 64'(len) * 64'd64;
      rem -= len;
    end
    for (int i = 0; i < v.n + 4; i++) begin
      src.push_back(rand_phit());
      stl.push_back(v.tlast_mode == 0 ? (i == v.n - 1) : (v.tlast_mode == 1 ? (i == 0) : 1'b0));
    end

    si = 0; pend_b = 0; b_issued = 0; done_cyc = -1; first_aw = -1; cyc = 0;
    b_hs = 0; t_hs = 0; fin = 0; err_at_done = 0;

    @(posedge ap_clk); #1;
    idle_inputs();
    start = 1'b1; base_addr = v.base; num_beats = 32'(v.n);
    @(posedge ap_clk); #1;

    while (!fin && cyc < 4000) begin
      if (v.poke != 0 && cyc == 2) begin
        start = 1'b1; base_addr = 64'h8000; num_beats = 32'd7;
      end else start = 1'b0;
      bus.m_axi_awready = rnd(v.aw_rate);
      bus.m_axi_wready  = rnd(v.w_rate);
      if (b_hs) bus.m_axi_bvalid = 1'b0;
      if (!bus.m_axi_bvalid && pend_b > 0 && rnd(60)) begin
        bus.m_axi_bvalid = 1'b1;
        bus.m_axi_bresp  = (b_issued == v.b_err_burst) ? 2'b10 : 2'b00;
        b_issued++;
        pend_b--;
      end
      if (!(bus.axis_tvalid && !t_hs)) begin
        if (si < src.size() && rnd(v.tv_rate)) begin
          bus.axis_tvalid = 1'b1; bus.axis_tdata = src[si]; bus.axis_tlast = stl[si];
        end else bus.axis_tvalid = 1'b0;
      end

      @(negedge ap_clk);
      b_hs = bus.m_axi_bvalid && bus.m_axi_bready;
      t_hs = bus.axis_tvalid && bus.axis_tready;
      if (bus.m_axi_awvalid && first_aw < 0) first_aw = cyc;
      if (bus.m_axi_awvalid && bus.m_axi_awready) begin
        got_a.push_back(bus.m_axi_awaddr);
        got_l.push_back(int'(bus.m_axi_awlen) + 1);
      end
      if (bus.m_axi_wvalid && bus.m_axi_wready) begin
        got_d.push_back(bus.m_axi_wdata);
        got_last.push_back(bus.m_axi_wlast);
        if (bus.m_axi_wlast) pend_b++;
      end
      if (t_hs) si++;
      if (done) begin
        fin = 1; done_cyc = cyc; err_at_done = err;
        if (v.poke != 0) begin
          start = 1'b1; base_addr = 64'h0; num_beats = 32'd5;
        end
      end
      @(posedge ap_clk); #1;
      cyc++;
    end

    idle_inputs();
    extra_done = 0; extra_busy = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge ap_clk);
      if (done) extra_done++;
      if (busy || bus.m_axi_awvalid) extra_busy++;
    end

    chk("done_seen", fin, 1);
    chk("n_bursts", got_a.size(), (v.exp_bursts < 0) ? ea.size() : v.exp_bursts);
    for (int i = 0; i < got_a.size() && i < ea.size(); i++) begin
      chk($sformatf("awaddr[%0d]", i), got_a[i], ea[i]);
      chk($sformatf("awlen+1[%0d]", i), got_l[i], el[i]);
    end
    chk("w_beats", got_d.size(), v.n);
    for (int i = 0; i < got_d.size() && i < v.n; i++) begin
      chk($sformatf("wdata[%0d]", i), got_d[i], src[i]);
      chk($sformatf("wlast[%0d]", i), got_last[i], elast[i]);
    end
    chk("beats_accepted", si, v.n);
    chk("err", err_at_done, v.exp_err);
    if (v.n == 0) chk("zero_len_done_latency", done_cyc, 0);
    else          chk("start_to_awvalid", first_aw, 0);
    chk("post_done_pulses", extra_done, 0);
    chk("post_done_busy", extra_busy, 0);
  endtask

  initial begin
    vecs.push_back(mk(64'h1000,               4,  100, 100, 100, -1, 0, 0, 1, 0));
    vecs.push_back(mk(64'h0,                  40, 100, 100, 100, -1, 0, 1, 3, 0));
    vecs.push_back(mk(64'hFC0,                3,  100, 100, 100, -1, 0, 0, 2, 0));
    vecs.push_back(mk(64'h2340,               50, 50,  50,  50,  -1, 0, 0, 4, 0));
    vecs.push_back(mk(64'h0,                  20, 100, 100, 100, 0,  0, 0, 2, 1));
    vecs.push_back(mk(64'h0,                  0,  100, 100, 100, -1, 0, 0, 0, 0));
    vecs.push_back(mk(64'h40,                 5,  100, 100, 100, -1, 1, 0, 1, 1));
    vecs.push_back(mk(64'h80,                 2,  50,  50,  50,  -1, 2, 0, 1, 1));
    vecs.push_back(mk(64'hF00,                70, 50,  50,  50,  -1, 0, 0, 6, 0));
    vecs.push_back(mk(64'hFFFF_FFFF_FFFF_FFC0, 3, 100, 100, 100, -1, 0, 0, 2, 0));
    vecs.push_back(mk(64'h1015,               2,  100, 100, 100, -1, 0, 0, 1, 0));
    for (int i = 0; i < 6; i++) begin
      logic [63:0] b;
      b = ({$urandom, $urandom} & ~64'hFFF) | (64'($urandom_range(48, 63)) << 6);
      vecs.push_back(mk(b, $urandom_range(1, 70), 50, 50, $urandom_range(30, 90), -1, 0, 0, -1, 0));
    end

    idle_inputs();
    repeat (3) @(posedge ap_clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_awvalid", bus.m_axi_awvalid, 0);
    chk("rst_wvalid", bus.m_axi_wvalid, 0);
    chk("rst_bready", bus.m_axi_bready, 0);
    chk("rst_tready", bus.axis_tready, 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    foreach (vecs[i]) run_xfer(vecs[i]);

    // Asynchronous reset while a burst is waiting in DATA.
    @(posedge ap_clk); #1;
    start = 1'b1; base_addr = 64'h0; num_beats = 32'd8;
    bus.m_axi_awready = 1'b1; bus.m_axi_wready = 1'b0;
    bus.axis_tvalid = 1'b1; bus.axis_tdata = rand_phit(); bus.axis_tlast = 1'b0;
    @(posedge ap_clk); #1;
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ap_clk);
      if (bus.m_axi_wvalid) break;
    end
    chk("rst_seq_in_data", bus.m_axi_wvalid, 1);
    #1 ap_rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_err", err, 0);
    chk("arst_awvalid", bus.m_axi_awvalid, 0);
    chk("arst_awaddr", bus.m_axi_awaddr, 0);
    chk("arst_wvalid", bus.m_axi_wvalid, 0);
    chk("arst_wdata", bus.m_axi_wdata, 0);
    chk("arst_wstrb", bus.m_axi_wstrb, 0);
    chk("arst_wlast", bus.m_axi_wlast, 0);
    chk("arst_bready", bus.m_axi_bready, 0);
    chk("arst_tready", bus.axis_tready, 0);
    idle_inputs();
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    run_xfer(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
